// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, frame type and segment decode table for the 7-segment display path
package seg7_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;
    localparam frame_t FRAME_RESET = '{digits: '0, blank: '1, dp: '0};
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: valid/ready frame transfer bundle between the digit source and the scan mux
interface seg7_scan_mux_if;
    import seg7_pkg::*;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] in_digits;
    logic [NUM_DIGITS-1:0]   in_blank;
    logic [NUM_DIGITS-1:0]   in_dp;
    modport master (output in_valid, in_digits, in_blank, in_dp, input in_ready);
    modport slave (input in_valid, in_digits, in_blank, in_dp, output in_ready);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low {G..A} segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: double-buffered 8-digit frame scanned onto shared segment lines with dead-time anodes
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    seg7_scan_mux_if.slave        frame,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    frame_t        active, pending;
    logic          pending_full;
    logic          tick, wrap, xfer, swap;
    logic [6:0]    dec_seg;

    assign tick = en & (prescaler == PW'(TICK_DIV - 1));
    assign wrap = tick & (idx == 3'd7);
    assign frame.in_ready = ~pending_full;
    assign xfer = frame.in_valid & ~pending_full;
    // disabled display has no frame boundary to wait for, so a pending frame goes live at once
    assign swap = pending_full & (~en | wrap);

    seg7_decode u_decode (
        .nib (active.digits[{idx, 2'b00} +: 4]),
        .seg (dec_seg)
    );

    // slot prescaler and digit index; both park at zero while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= (~en | tick) ? '0 : prescaler + 1'b1;
            idx        <= en ? idx + 3'(tick) : 3'd0;
            frame_done <= wrap;
        end
    end

    // pending/active double buffer; active only changes on a wrap or while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= FRAME_RESET;
            active       <= FRAME_RESET;
            pending_full <= 1'b0;
        end else begin
            if (xfer) begin
                pending      <= '{digits: frame.in_digits, blank: frame.in_blank, dp: frame.in_dp};
                pending_full <= 1'b1;
            end else if (swap) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
        end
    end

    // registered pin drivers; prescaler doubles as the cycles-since-idx-change counter for dead time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= (~en | (prescaler < PW'(DEAD_CYC))) ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg <= active.blank[idx] ? SEG_BLANK : dec_seg;
            dp  <= active.blank[idx] | ~active.dp[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed frame sequence with a per-digit scoreboard of expected anode/segment/dp
module tb_seg7_scan_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    int         passed = 0;
    int         total = 0;
    int         n;
    logic       bad;
    logic [7:0] prev_an = 8'hFF;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t sb[$];

    logic [6:0] tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_mux_if fif ();

    seg7_scan_mux #(.TICK_DIV(4), .DEAD_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .frame      (fif),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic push_frame(input logic [31:0] digits, input logic [7:0] blank, input logic [7:0] dpm);
        exp_t e;
        for (int d = 0; d < 8; d++) begin
            e.an  = ~(8'h01 << d);
            e.seg = blank[d] ? 7'h7F : tab[digits[4*d +: 4]];
            e.dp  = blank[d] | ~dpm[d];
            sb.push_back(e);
        end
    endtask

    task automatic offer(input logic [31:0] digits, input logic [7:0] blank, input logic [7:0] dpm);
        fif.in_digits = digits;
        fif.in_blank  = blank;
        fif.in_dp     = dpm;
        fif.in_valid  = 1'b1;
    endtask

    task automatic wait_fd();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        check("fd_seen", frame_done, 1'b1);
    endtask

    // each first lit cycle of a slot is checked against the next scoreboard entry
    always @(negedge clk) begin
        if (an !== 8'hFF && prev_an === 8'hFF && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("scan_an", an, e.an);
            check("scan_seg", seg, e.seg);
            check("scan_dp", dp, e.dp);
        end
        prev_an = an;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        en = 1'b1;
        fif.in_valid = 1'b0;
        fif.in_digits = '0;
        fif.in_blank = '0;
        fif.in_dp = '0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        check("rst_rdy", fif.in_ready, 1'b1);
        rst = 1'b1;
        wait_fd();
        @(negedge clk);
        check("fd_width", frame_done, 1'b0);
        n = 1;
        bad = 1'b0;
        while (frame_done !== 1'b1 && n < 100) begin
            bad |= (seg !== 7'h7F) | (dp !== 1'b1) | (fif.in_ready !== 1'b1);
            @(negedge clk);
            n++;
        end
        check("idle_period", n, 32);
        check("idle_blank", bad, 1'b0);
        repeat (5) @(negedge clk);
        offer(32'h1994_0527, 8'h00, 8'h04);
        @(negedge clk);
        check("a_accept", fif.in_ready, 1'b0);
        fif.in_valid = 1'b0;
        wait_fd();
        check("a_swap_rdy", fif.in_ready, 1'b1);
        push_frame(32'h1994_0527, 8'h00, 8'h04);
        @(negedge clk);
        check("a_dead", an, 8'hFF);
        @(negedge clk);
        check("a_d0_an", an, 8'hFE);
        check("a_d0_seg", seg, 7'b1011000);
        repeat (3) @(negedge clk);
        offer(32'h0123_4567, 8'h00, 8'h81);
        @(negedge clk);
        check("b_accept", fif.in_ready, 1'b0);
        offer(32'h89AB_CDEF, 8'h00, 8'h10);
        n = 0;
        while (fif.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c_held_to_wrap", frame_done, 1'b1);
        push_frame(32'h0123_4567, 8'h00, 8'h81);
        @(negedge clk);
        check("c_accept", fif.in_ready, 1'b0);
        fif.in_valid = 1'b0;
        wait_fd();
        push_frame(32'h89AB_CDEF, 8'h00, 8'h10);
        repeat (31) @(negedge clk);
        offer(32'h3141_5926, 8'h00, 8'h00);
        @(negedge clk);
        check("d_on_wrap", frame_done, 1'b1);
        check("d_accept", fif.in_ready, 1'b0);
        fif.in_valid = 1'b0;
        push_frame(32'h89AB_CDEF, 8'h00, 8'h10);
        wait_fd();
        push_frame(32'h3141_5926, 8'h00, 8'h00);
        wait_fd();
        repeat (5) @(negedge clk);
        offer(32'h8888_8888, 8'hF0, 8'h00);
        @(negedge clk);
        fif.in_valid = 1'b0;
        wait_fd();
        push_frame(32'h8888_8888, 8'hF0, 8'h00);
        wait_fd();
        repeat (8) @(negedge clk);
        offer(32'hFEDC_BA98, 8'h20, 8'h01);
        @(negedge clk);
        check("f_accept", fif.in_ready, 1'b0);
        fif.in_valid = 1'b0;
        en = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad |= (an !== 8'hFF) | (frame_done !== 1'b0);
        end
        check("en_low_dark", bad, 1'b0);
        check("f_swap_rdy", fif.in_ready, 1'b1);
        push_frame(32'hFEDC_BA98, 8'h20, 8'h01);
        en = 1'b1;
        @(negedge clk);
        check("f_restart_dead", an, 8'hFF);
        @(negedge clk);
        check("f_first_an", an, 8'hFE);
        check("f_first_dp", dp, 1'b0);
        wait_fd();
        check("f_wrap_time", n, 30);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
